// File: rtl/subterranean_ctrl_pkg.sv
// Shared definitions for the Subterranean SAE controller.
// Holds the controller state encoding, the lane/byte geometry of the
// 4-lane duplex datapath and the two fixed lane-size words.
package subterranean_ctrl_pkg;

    localparam int LANES      = 4;
    localparam int LANE_BYTES = 4;
    localparam int DATA_W     = 128;
    localparam int BYTES_W    = 5;
    localparam int SIZE_W     = 12;

    // Every lane carries 4 bytes / every lane is empty.
    localparam logic [SIZE_W-1:0] SIZE_FULL  = 12'h924;
    localparam logic [SIZE_W-1:0] SIZE_EMPTY = 12'h000;

    typedef enum logic [3:0] {
        IDLE,
        CLEAR,
        KEY,
        KEY_PAD,
        NONCE,
        NONCE_PAD,
        BLANK,
        AD,
        AD_PAD,
        MSG,
        MSG_PAD,
        FINAL,
        TAG
    } state_t;

endpackage

// File: rtl/subterranean_lane_size_encoder.sv
// Converts a host beat byte count into datapath lane controls.
// Ports:
//   bytes        - valid bytes in the beat (values above 16 act as 16)
//   last         - beat closes its stream
//   enable_round - rounds this beat minus 1
//   din_size     - 3 bits per lane, lane byte count 0..4
//   needs_pad    - a full last beat must be followed by one empty-lane beat
module subterranean_lane_size_encoder
    import subterranean_ctrl_pkg::*;
(
    input  logic [BYTES_W-1:0] bytes,
    input  logic               last,
    output logic [1:0]         enable_round,
    output logic [SIZE_W-1:0]  din_size,
    output logic               needs_pad
);

    logic [BYTES_W-1:0] n;
    logic [BYTES_W-1:0] rem;
    logic [2:0]         take;

    always_comb begin
        n            = (bytes > 5'd16) ? 5'd16 : bytes;
        enable_round = 2'b11;
        din_size     = SIZE_FULL;
        needs_pad    = 1'b0;
        rem          = n;
        take         = 3'd0;
        if (!last || n == 5'd16) begin
            // Non-last beats are always full; a full last beat leaves no
            // room for the pad marker, so an extra empty lane follows.
            needs_pad = last;
        end else begin
            enable_round = n[3:2];
            din_size     = SIZE_EMPTY;
            // Fill lanes low to high, 4 bytes each, remainder in the top one.
            for (int i = 0; i < LANES; i++) begin
                take              = (rem > 5'd4) ? 3'd4 : rem[2:0];
                din_size[3*i +: 3] = take;
                rem               = rem - {2'b00, take};
            end
        end
    end

endmodule

// File: rtl/subterranean_sae_controller.sv
// Sequencer for a complete Subterranean SAE operation on the 4-lane duplex
// datapath: clear, key, nonce, blank rounds, AD, message, final blank
// rounds and tag squeeze.
// Ports:
//   clk, arstn                 - clock, synchronous active-low reset
//   start/mode/key/nonce/tag_in - operation request, latched in IDLE
//   busy                       - high outside IDLE
//   data_in*                   - host input stream (AD then message)
//   data_out*                  - message output stream (pass-through)
//   tag_out/tag_valid/tag_match - tag result, held until the next start
//   dp_*                       - every datapath control and data port
module subterranean_sae_controller
    import subterranean_ctrl_pkg::*;
#(
    parameter int BLANK_ROUNDS = 8
)
(
    input  logic                clk,
    input  logic                arstn,
    input  logic                start,
    input  logic                mode,
    input  logic [DATA_W-1:0]   key,
    input  logic [DATA_W-1:0]   nonce,
    input  logic [DATA_W-1:0]   tag_in,
    output logic                busy,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [BYTES_W-1:0]  data_in_bytes,
    input  logic                data_in_last,
    input  logic                data_in_valid,
    output logic                data_in_ready,
    output logic [DATA_W-1:0]   data_out,
    output logic [BYTES_W-1:0]  data_out_bytes,
    output logic                data_out_valid,
    input  logic                data_out_ready,
    output logic [DATA_W-1:0]   tag_out,
    output logic                tag_valid,
    output logic                tag_match,
    output logic                dp_init,
    output logic                dp_encrypt,
    output logic                dp_decrypt,
    output logic [1:0]          dp_enable_round,
    output logic [DATA_W-1:0]   dp_din,
    output logic [SIZE_W-1:0]   dp_din_size,
    output logic                dp_din_valid,
    output logic                dp_dout_ready,
    input  logic                dp_din_ready,
    input  logic [DATA_W-1:0]   dp_dout,
    input  logic                dp_dout_valid
);

    localparam int BLANK_BEATS = BLANK_ROUNDS / 4;
    localparam int CNT_W       = (BLANK_BEATS > 1) ? $clog2(BLANK_BEATS) : 1;

    state_t              state;
    logic                mode_r;
    logic [DATA_W-1:0]   key_r;
    logic [DATA_W-1:0]   nonce_r;
    logic [DATA_W-1:0]   tag_in_r;
    logic [CNT_W-1:0]    beat_cnt;
    logic                last_blank;
    logic [1:0]          enc_enable;
    logic [SIZE_W-1:0]   enc_size;
    logic                enc_pad;

    // Beats commit on dp_din_valid & dp_dout_ready; the datapath's own
    // ready/valid pair carries no extra information for this sequencer.
    logic                unused_inputs;
    assign unused_inputs = dp_din_ready ^ dp_dout_valid;

    subterranean_lane_size_encoder u_size_enc (
        .bytes        (data_in_bytes),
        .last         (data_in_last),
        .enable_round (enc_enable),
        .din_size     (enc_size),
        .needs_pad    (enc_pad)
    );

    assign last_blank = (beat_cnt == CNT_W'(BLANK_BEATS - 1));

    // Datapath and stream controls decoded from the registered state.
    always_comb begin
        busy            = (state != IDLE);
        dp_init         = (state == CLEAR);
        dp_encrypt      = 1'b0;
        dp_decrypt      = 1'b0;
        dp_enable_round = 2'b00;
        dp_din          = '0;
        dp_din_size     = SIZE_EMPTY;
        dp_din_valid    = 1'b0;
        dp_dout_ready   = 1'b0;
        data_in_ready   = 1'b0;
        data_out        = '0;
        data_out_bytes  = '0;
        data_out_valid  = 1'b0;
        case (state)
            KEY, NONCE: begin
                dp_din          = (state == KEY) ? key_r : nonce_r;
                dp_din_size     = SIZE_FULL;
                dp_enable_round = 2'b11;
                dp_din_valid    = 1'b1;
                dp_dout_ready   = 1'b1;
            end
            KEY_PAD, NONCE_PAD, AD_PAD: begin
                dp_din_valid    = 1'b1;
                dp_dout_ready   = 1'b1;
            end
            BLANK, FINAL, TAG: begin
                dp_enable_round = 2'b11;
                dp_din_valid    = 1'b1;
                dp_dout_ready   = 1'b1;
            end
            AD: begin
                data_in_ready   = 1'b1;
                dp_din          = data_in;
                dp_din_size     = enc_size;
                dp_enable_round = enc_enable;
                dp_din_valid    = data_in_valid;
                dp_dout_ready   = 1'b1;
            end
            MSG: begin
                // Output is a straight pass-through, so input acceptance
                // follows the output consumer.
                dp_encrypt      = ~mode_r;
                dp_decrypt      = mode_r;
                data_in_ready   = data_out_ready;
                dp_din          = data_in;
                dp_din_size     = enc_size;
                dp_enable_round = enc_enable;
                dp_din_valid    = data_in_valid;
                dp_dout_ready   = data_out_ready;
                data_out        = dp_dout;
                data_out_bytes  = data_in_bytes;
                data_out_valid  = data_in_valid;
            end
            MSG_PAD: begin
                // Pad lane still belongs to the message stream.
                dp_encrypt      = ~mode_r;
                dp_decrypt      = mode_r;
                dp_din_valid    = 1'b1;
                dp_dout_ready   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arstn) begin
            state     <= IDLE;
            mode_r    <= 1'b0;
            key_r     <= '0;
            nonce_r   <= '0;
            tag_in_r  <= '0;
            beat_cnt  <= '0;
            tag_out   <= '0;
            tag_valid <= 1'b0;
            tag_match <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_r    <= mode;
                        key_r     <= key;
                        nonce_r   <= nonce;
                        tag_in_r  <= tag_in;
                        tag_valid <= 1'b0;
                        tag_match <= 1'b0;
                        state     <= CLEAR;
                    end
                end
                CLEAR:     state <= KEY;
                KEY:       state <= KEY_PAD;
                KEY_PAD:   state <= NONCE;
                NONCE:     state <= NONCE_PAD;
                NONCE_PAD: begin
                    beat_cnt <= '0;
                    state    <= BLANK;
                end
                BLANK: begin
                    if (last_blank) begin
                        beat_cnt <= '0;
                        state    <= AD;
                    end else begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                AD: begin
                    if (data_in_valid && data_in_last)
                        state <= enc_pad ? AD_PAD : MSG;
                end
                AD_PAD:    state <= MSG;
                MSG: begin
                    if (data_in_valid && data_out_ready && data_in_last)
                        state <= enc_pad ? MSG_PAD : FINAL;
                end
                MSG_PAD:   state <= FINAL;
                FINAL: begin
                    if (last_blank) begin
                        beat_cnt <= '0;
                        state    <= TAG;
                    end else begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                TAG: begin
                    tag_out   <= dp_dout;
                    tag_match <= mode_r && (dp_dout == tag_in_r);
                    tag_valid <= 1'b1;
                    state     <= IDLE;
                end
                default:   state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_subterranean_sae_controller.sv
// Directed bench for subterranean_sae_controller with a toy duplex
// datapath model: keystream from state, plaintext absorbed in both modes.
module tb_subterranean_sae_controller;

    logic         clk = 1'b0;
    logic         arstn, start, mode;
    logic [127:0] key, nonce, tag_in;
    logic         busy;
    logic [127:0] data_in;
    logic [4:0]   data_in_bytes;
    logic         data_in_last, data_in_valid, data_in_ready;
    logic [127:0] data_out;
    logic [4:0]   data_out_bytes;
    logic         data_out_valid, data_out_ready;
    logic [127:0] tag_out;
    logic         tag_valid, tag_match;
    logic         dp_init, dp_encrypt, dp_decrypt;
    logic [1:0]   dp_enable_round;
    logic [127:0] dp_din;
    logic [11:0]  dp_din_size;
    logic         dp_din_valid, dp_dout_ready, dp_din_ready;
    logic [127:0] dp_dout;
    logic         dp_dout_valid;

    always #5 clk = ~clk;

    subterranean_sae_controller #(.BLANK_ROUNDS(8)) dut (
        .clk(clk), .arstn(arstn), .start(start), .mode(mode), .key(key),
        .nonce(nonce), .tag_in(tag_in), .busy(busy), .data_in(data_in),
        .data_in_bytes(data_in_bytes), .data_in_last(data_in_last),
        .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
        .data_out(data_out), .data_out_bytes(data_out_bytes),
        .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
        .tag_out(tag_out), .tag_valid(tag_valid), .tag_match(tag_match),
        .dp_init(dp_init), .dp_encrypt(dp_encrypt), .dp_decrypt(dp_decrypt),
        .dp_enable_round(dp_enable_round), .dp_din(dp_din),
        .dp_din_size(dp_din_size), .dp_din_valid(dp_din_valid),
        .dp_dout_ready(dp_dout_ready), .dp_din_ready(dp_din_ready),
        .dp_dout(dp_dout), .dp_dout_valid(dp_dout_valid)
    );

    localparam logic [127:0] KEY1   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] NONCE1 = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
    localparam logic [127:0] KS_C   = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] PT1    = 128'h00000000000000000000000000636261;
    localparam logic [127:0] AD5    = 128'h0000000000000000000000110a0b0c0d;

    // Toy datapath
    logic [127:0] dp_state = '0;
    logic [127:0] ks;

    function automatic logic [127:0] size_mask(input logic [11:0] s);
        logic [127:0] m = '0;
        for (int i = 0; i < 4; i++)
            for (int b = 0; b < 4; b++)
                if (b < int'(s[3*i +: 3])) m[32*i + 8*b +: 8] = 8'hff;
        return m;
    endfunction

    assign ks            = {dp_state[63:0], dp_state[127:64]} ^ KS_C;
    assign dp_dout       = dp_din ^ ks;
    assign dp_din_ready  = 1'b1;
    assign dp_dout_valid = 1'b1;

    always @(posedge clk) begin
        if (dp_init)
            dp_state <= '0;
        else if (dp_din_valid && dp_dout_ready)
            dp_state <= {dp_state[126:0], dp_state[127]}
                        ^ ((dp_decrypt ? dp_dout : dp_din) & size_mask(dp_din_size))
                        ^ {114'd0, dp_enable_round, dp_din_size};
    end

    // Commit log
    logic [1:0]   log_en   [0:31];
    logic [11:0]  log_size [0:31];
    logic         log_enc  [0:31];
    logic         log_dec  [0:31];
    logic [127:0] log_din  [0:31];
    logic [127:0] log_dout [0:31];
    int ncommit = 0, busy_cycles = 0, init_pulses = 0;

    always @(negedge clk) begin
        if (dp_din_valid && dp_dout_ready) begin
            if (ncommit < 32) begin
                log_en[ncommit]   = dp_enable_round;
                log_size[ncommit] = dp_din_size;
                log_enc[ncommit]  = dp_encrypt;
                log_dec[ncommit]  = dp_decrypt;
                log_din[ncommit]  = dp_din;
                log_dout[ncommit] = dp_dout;
            end
            ncommit++;
        end
        if (busy) busy_cycles++;
        if (dp_init) init_pulses++;
    end

    int checks = 0, errors = 0;

    task automatic check_eq(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Stream stimulus
    logic [127:0] ad_data  [0:1];
    logic [4:0]   ad_bytes [0:1];
    int           ad_n;
    logic [127:0] msg_data [0:1];
    logic [4:0]   msg_bytes[0:1];
    int           msg_n;
    logic [127:0] out_data [0:1];
    logic [4:0]   out_bytes[0:1];
    int           stall_cycles;
    logic         busy_at_tag;

    task automatic send_beat(input logic [127:0] d, input logic [4:0] b, input logic l,
                             output logic [127:0] od, output logic [4:0] ob);
        bit done = 0;
        od = '0;
        ob = '0;
        data_in = d; data_in_bytes = b; data_in_last = l; data_in_valid = 1'b1;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (data_in_ready) begin
                od   = data_out;
                ob   = data_out_bytes;
                done = 1;
            end
        end
        check_eq("beat_accepted", 128'(done), 128'd1);
        @(posedge clk); #1;
        data_in_valid = 1'b0;
    endtask

    task automatic wait_msg_stall(input int cycles);
        bit seen = 0;
        int n0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            seen = data_out_valid;
        end
        check_eq("msg_reached", 128'(seen), 128'd1);
        n0 = ncommit;
        for (int k = 0; k < cycles; k++) begin
            if (k > 0) @(negedge clk);
            check_eq("stall_in_ready", 128'(data_in_ready), 128'd0);
            check_eq("stall_no_commit", 128'(dp_din_valid & dp_dout_ready), 128'd0);
        end
        check_eq("stall_commit_count", 128'(ncommit), 128'(n0));
    endtask

    task automatic run_op(input logic m, input logic [127:0] k, input logic [127:0] t, input bit glitch);
        logic [127:0] od;
        logic [4:0]   ob;
        bit seen = 0;
        busy_cycles = 0; ncommit = 0; init_pulses = 0;
        @(posedge clk); #1;
        start = 1'b1; mode = m; key = k; nonce = NONCE1; tag_in = t;
        @(posedge clk); #1;
        start = 1'b0;
        if (glitch) begin
            start = 1'b1; key = ~k; mode = ~m;
            @(posedge clk); #1;
            start = 1'b0;
        end
        for (int i = 0; i < ad_n; i++)
            send_beat(ad_data[i], ad_bytes[i], (i == ad_n - 1), od, ob);
        for (int i = 0; i < msg_n; i++) begin
            if (i == 0 && stall_cycles > 0) begin
                data_out_ready = 1'b0;
                data_in = msg_data[0]; data_in_bytes = msg_bytes[0];
                data_in_last = (msg_n == 1); data_in_valid = 1'b1;
                wait_msg_stall(stall_cycles);
                @(posedge clk); #1;
                data_out_ready = 1'b1;
            end
            send_beat(msg_data[i], msg_bytes[i], (i == msg_n - 1), out_data[i], out_bytes[i]);
        end
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            seen = tag_valid;
        end
        busy_at_tag = busy;
        check_eq("tag_valid", 128'(seen), 128'd1);
    endtask

    logic [127:0] tag1, ct1;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        arstn = 1'b0; start = 1'b0; mode = 1'b0; key = '0; nonce = '0; tag_in = '0;
        data_in = '0; data_in_bytes = '0; data_in_last = 1'b0; data_in_valid = 1'b0;
        data_out_ready = 1'b1; stall_cycles = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ctrl", 128'({busy, dp_din_valid, data_in_ready, tag_valid, tag_match, dp_init}), 128'd0);
        check_eq("rst_tag_out", tag_out, 128'd0);
        @(posedge clk); #1;
        arstn = 1'b1;

        // Encrypt: AD 5 bytes, message 3 bytes
        ad_n = 1; ad_data[0] = AD5; ad_bytes[0] = 5'd5;
        msg_n = 1; msg_data[0] = PT1; msg_bytes[0] = 5'd3;
        run_op(1'b0, KEY1, 128'd0, 1'b0);
        check_eq("enc_busy_cycles", 128'(busy_cycles), 128'd12);
        check_eq("enc_busy_low_at_tag", 128'(busy_at_tag), 128'd0);
        check_eq("enc_commits", 128'(ncommit), 128'd11);
        check_eq("enc_init_pulses", 128'(init_pulses), 128'd1);
        check_eq("key_din", log_din[0], KEY1);
        check_eq("key_ctrl", 128'({log_en[0], log_size[0]}), 128'({2'b11, 12'h924}));
        check_eq("key_pad_ctrl", 128'({log_en[1], log_size[1], log_din[1]}), 128'd0);
        check_eq("nonce_din", log_din[2], NONCE1);
        check_eq("blank_ctrl", 128'({log_en[4], log_size[4], log_en[5], log_size[5]}),
                 128'({2'b11, 12'h000, 2'b11, 12'h000}));
        check_eq("ad5_ctrl", 128'({log_en[6], log_size[6]}), 128'({2'b01, 12'h00C}));
        check_eq("ad5_din", log_din[6], AD5);
        check_eq("msg3_ctrl", 128'({log_en[7], log_size[7], log_enc[7], log_dec[7]}),
                 128'({2'b00, 12'h003, 1'b1, 1'b0}));
        check_eq("msg3_out_bytes", 128'(out_bytes[0]), 128'd3);
        check_eq("msg3_data_out", out_data[0], log_dout[7]);
        check_eq("tag_beat_ctrl", 128'({log_en[10], log_size[10], log_enc[10], log_dec[10]}),
                 128'({2'b11, 12'h000, 1'b0, 1'b0}));
        check_eq("enc_tag_out", tag_out, log_dout[10]);
        check_eq("enc_tag_match", 128'(tag_match), 128'd0);
        tag1 = tag_out;
        ct1  = out_data[0];

        // Decrypt with the matching tag
        msg_data[0] = ct1;
        run_op(1'b1, KEY1, tag1, 1'b0);
        check_eq("dec_plaintext", out_data[0], PT1);
        check_eq("dec_msg_flags", 128'({log_enc[7], log_dec[7]}), 128'({1'b0, 1'b1}));
        check_eq("dec_tag_out", tag_out, tag1);
        check_eq("dec_tag_match", 128'(tag_match), 128'd1);

        // Decrypt with one tag bit flipped
        run_op(1'b1, KEY1, tag1 ^ 128'd1, 1'b0);
        check_eq("bad_tag_match", 128'(tag_match), 128'd0);

        // AD of exactly 16 bytes, empty message
        ad_data[0] = 128'hffeeddccbbaa99887766554433221100; ad_bytes[0] = 5'd16;
        msg_data[0] = '0; msg_bytes[0] = 5'd0;
        run_op(1'b0, KEY1, 128'd0, 1'b0);
        check_eq("ad16_commits", 128'(ncommit), 128'd12);
        check_eq("ad16_busy_cycles", 128'(busy_cycles), 128'd13);
        check_eq("ad16_ctrl", 128'({log_en[6], log_size[6]}), 128'({2'b11, 12'h924}));
        check_eq("ad_pad_ctrl", 128'({log_en[7], log_size[7], log_enc[7]}), 128'({2'b00, 12'h000, 1'b0}));
        check_eq("empty_msg_ctrl", 128'({log_en[8], log_size[8], log_enc[8]}), 128'({2'b00, 12'h000, 1'b1}));
        check_eq("empty_msg_bytes", 128'(out_bytes[0]), 128'd0);

        // Empty AD, two 16-byte message beats, output stalled 3 cycles
        ad_data[0] = '0; ad_bytes[0] = 5'd0;
        msg_n = 2;
        msg_data[0] = 128'h1111111122222222333333334444444; msg_bytes[0] = 5'd16;
        msg_data[1] = 128'h5555555566666666777777778888888; msg_bytes[1] = 5'd16;
        stall_cycles = 3;
        run_op(1'b0, KEY1, 128'd0, 1'b0);
        stall_cycles = 0;
        check_eq("stall_commits", 128'(ncommit), 128'd13);
        check_eq("empty_ad_ctrl", 128'({log_en[6], log_size[6]}), 128'd0);
        check_eq("msg16_ctrl", 128'({log_en[8], log_size[8]}), 128'({2'b11, 12'h924}));
        check_eq("msg_pad_ctrl", 128'({log_en[9], log_size[9], log_din[9]}), 128'd0);
        check_eq("final_after_pad", 128'({log_en[10], log_size[10]}), 128'({2'b11, 12'h000}));

        // start pulsed while busy must be ignored
        ad_n = 1; ad_data[0] = AD5; ad_bytes[0] = 5'd5;
        msg_n = 1; msg_data[0] = PT1; msg_bytes[0] = 5'd3;
        run_op(1'b0, KEY1, 128'd0, 1'b1);
        check_eq("glitch_busy_cycles", 128'(busy_cycles), 128'd12);
        check_eq("glitch_key_din", log_din[0], KEY1);
        check_eq("glitch_tag_out", tag_out, tag1);

        // Reset in the middle of the message stream
        ncommit = 0;
        @(posedge clk); #1;
        start = 1'b1; mode = 1'b0; key = KEY1; nonce = NONCE1;
        @(posedge clk); #1;
        start = 1'b0;
        send_beat(AD5, 5'd5, 1'b1, ct1, msg_bytes[1]);
        data_out_ready = 1'b0;
        data_in = PT1; data_in_bytes = 5'd3; data_in_last = 1'b1; data_in_valid = 1'b1;
        wait_msg_stall(1);
        @(posedge clk); #1;
        arstn = 1'b0; data_in_valid = 1'b0; data_out_ready = 1'b1;
        @(posedge clk); #1;
        arstn = 1'b1;
        @(negedge clk);
        check_eq("mrst_ctrl", 128'({busy, dp_din_valid, dp_dout_ready, dp_init, dp_encrypt, dp_decrypt,
                 dp_enable_round, dp_din_size, data_in_ready, data_out_bytes, data_out_valid,
                 tag_valid, tag_match}), 128'd0);
        check_eq("mrst_dp_din", dp_din, 128'd0);
        check_eq("mrst_data_out", data_out, 128'd0);
        check_eq("mrst_tag_out", tag_out, 128'd0);
        tag1 = 128'(ncommit);
        repeat (10) @(negedge clk);
        check_eq("mrst_no_commits", 128'(ncommit), tag1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/subterranean_sae_controller.md
Name: subterranean_sae_controller

Overview:
- Sequencer for the 4-lane Subterranean duplex datapath (clear, 1–4 rounds per beat, 32-bit lanes with per-lane byte size).
- Runs a complete SAE operation: key absorb, nonce absorb, blank rounds, AD absorb, message encrypt/decrypt, final blank rounds, tag squeeze.
- Sits between the host stream interface and the datapath and owns every datapath control input.

Parameters:
- BLANK_ROUNDS, 8, number of empty-lane duplex rounds after the nonce and before the tag; must be a multiple of 4.

Ports:
- clk  in  1  clock
- arstn  in  1  synchronous active-low reset
- start  in  1  begin an operation; sampled in IDLE only
- mode  in  1  0 = encrypt, 1 = decrypt; latched at start
- key  in  128  latched at start
- nonce  in  128  latched at start
- tag_in  in  128  expected tag for decrypt; latched at start
- busy  out  1  high in every state except IDLE
- data_in  in  128  AD then message bytes, packed from bit 0
- data_in_bytes  in  5  valid bytes in the beat, 0..16
- data_in_last  in  1  last beat of the current stream (AD or message)
- data_in_valid  in  1  input handshake
- data_in_ready  out  1  input handshake
- data_out  out  128  ciphertext or plaintext
- data_out_bytes  out  5  equals data_in_bytes of the message beat
- data_out_valid  out  1  output handshake
- data_out_ready  in  1  output handshake
- tag_out  out  128  computed tag
- tag_valid  out  1  high from tag capture until the next accepted start
- tag_match  out  1  decrypt only: tag_out == tag_in; valid with tag_valid
- dp_init, dp_encrypt, dp_decrypt  out  1 each  datapath mode controls
- dp_enable_round  out  2  rounds this beat minus 1
- dp_din  out  128  datapath input
- dp_din_size  out  12  3 bits per lane; lane i uses bits [3i+2:3i]; value is the lane byte count, 0..4
- dp_din_valid  out  1  datapath handshake
- dp_dout_ready  out  1  datapath handshake
- dp_din_ready  in  1  datapath handshake
- dp_dout  in  128  datapath output
- dp_dout_valid  in  1  datapath handshake

Behaviour:
- Reset (synchronous, arstn low at a clk edge): state goes to IDLE. Every output is 0, tag_out is 0, and latched registers are cleared. Reset mid-operation aborts with no further datapath commits.
- The datapath commits a beat when dp_din_valid & dp_dout_ready. For internal beats the controller drives both high, giving one beat per cycle.
- IDLE: on start, latch mode/key/nonce/tag_in, clear tag_valid, go to CLEAR. start while busy is ignored.
- CLEAR: dp_init=1 for 1 cycle, then KEY.
- KEY: 2 beats.
  - Beat 1: din=key, size 12'h924, enable 11.
  - Beat 2: din=0, size 0, enable 00. This is the empty pad lane.
- NONCE: 2 beats, same pattern with nonce.
- BLANK: BLANK_ROUNDS/4 beats with din=0, size 0, enable 11, then AD.
- AD: data_in_ready=1; dp_din_valid=data_in_valid; dp_dout_ready=1; dp_din=data_in.
  - Non-last beat: treated as 16 bytes (size 12'h924, enable 11).
  - Last beat with n<16: enable=n>>2, lane i size=min(4, n−4i) for i≤n>>2, higher lanes 0. Example: n=5 gives enable 01, size 12'h00C.
  - Last beat with n=16: full beat, then one AD_PAD beat (1 empty lane), then MSG.
  - After a last beat with n<16, go directly to MSG.
- MSG: same lane encoding as AD, with dp_encrypt=~mode and dp_decrypt=mode.
  - dp_din_valid=data_in_valid; dp_dout_ready=data_out_ready; data_in_ready=data_out_ready.
  - data_out=dp_dout; data_out_valid=data_in_valid (combinational pass-through; zero added latency).
  - Last beat with n=16 is followed by MSG_PAD (1 empty lane, no output).
- FINAL: BLANK_ROUNDS/4 empty beats.
- TAG: 1 beat, din=0, size 0, enable 11, encrypt/decrypt low. Capture dp_dout into tag_out and compute tag_match (0 when mode=0). Set tag_valid. Go to IDLE.
- Every stream needs at least one beat; an empty stream is one beat with bytes=0 and last=1.
- data_in_bytes>16 is treated as 16.

Decomposition:
- Package subterranean_ctrl_pkg holds:
  - the state encoding (IDLE, CLEAR, KEY, KEY_PAD, NONCE, NONCE_PAD, BLANK, AD, AD_PAD, MSG, MSG_PAD, FINAL, TAG)
  - SIZE_FULL = 12'h924 and SIZE_EMPTY = 12'h000
  - the lane and byte width constants
- Sub-module subterranean_lane_size_encoder: input bytes and last; outputs dp_enable_round, dp_din_size, and a needs_pad flag.

Test Plan:
- Encrypt with AD=5 bytes and msg=3 bytes, both single last beats → busy high 12 cycles (CLEAR 1, KEY 2, NONCE 2, BLANK 2, AD 1, MSG 1, FINAL 2, TAG 1). AD beat has enable 01 and size 12'h00C; MSG beat has enable 00, size 12'h003, data_out_bytes=3. tag_valid rises the cycle after TAG.
- AD of exactly 16 bytes plus empty message → AD_PAD beat (enable 00, size 0) is inserted; MSG beat has size 0 and data_out_bytes=0.
- Message of two 16-byte beats with data_out_ready low for 3 cycles → no dp commits and no data_in acceptance while stalled; MSG_PAD follows the second beat.
- Decrypt of the ciphertext from the first scenario with its tag → plaintext matches and tag_match=1. Repeat with one flipped tag_in bit → tag_match=0.
- arstn low during MSG → next cycle busy=0, all outputs 0, and no dp_din_valid until a new start.
- start pulsed while busy → ignored; latched key is unchanged and operation cycle count is unaffected.
